// File: rtl/nx_stream_pkg.sv
// Shared types for the nx stream adapters.
// Buffer-count type and the read-buffer depth.
package nx_stream_pkg;

  localparam int NX_RD_BUF_DEPTH = 2;

  typedef logic [1:0] nx_buf_cnt_t;

  localparam nx_buf_cnt_t NX_BUF_EMPTY = 2'd0;
  localparam nx_buf_cnt_t NX_BUF_ONE   = 2'd1;
  localparam nx_buf_cnt_t NX_BUF_FULL  = 2'(NX_RD_BUF_DEPTH);

endpackage

// File: rtl/nx_fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter.
// Two-slot registered shift buffer; count doubles as FSM state.
module nx_fifo_rd_stream
  import nx_stream_pkg::*;
#(
  parameter int WIDTH      = 256,
  parameter int CNT_W      = 16,
  parameter int DATA_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       buf_cnt,
  output logic [CNT_W-1:0] rd_count
);

  nx_buf_cnt_t      r_cnt;
  nx_buf_cnt_t      w_cnt_nxt;
  logic             r_valid;
  logic [WIDTH-1:0] r_s0;
  logic [WIDTH-1:0] r_s1;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             w_pop;
  logic             w_ren;
  nx_buf_cnt_t      w_idx;

  // State register: count, registered valid, delivered counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= NX_BUF_EMPTY;
      r_valid  <= 1'b0;
      r_rd_cnt <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_valid  <= (w_cnt_nxt != NX_BUF_EMPTY);
      r_rd_cnt <= r_rd_cnt + CNT_W'(w_pop);
    end
  end

  // Next-state: net of one push and one pop; flush empties
  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (1'b1)
      flush:   w_cnt_nxt = NX_BUF_EMPTY;
      default: w_cnt_nxt = r_cnt + {1'b0, w_ren}
                                 - {1'b0, w_pop};
    endcase
  end

  // Outputs: pop handshake, FIFO read strobe, push slot
  always_comb begin
    w_pop = r_valid & out_ready;
    w_ren = !rst && !flush && !fifo_empty
            && ((r_cnt != NX_BUF_FULL) || w_pop);
    w_idx = r_cnt - {1'b0, w_pop};
  end

  // Data slots: shift on pop, then land new word
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      if (DATA_RESET != 0) begin
        r_s0 <= '0;
        r_s1 <= '0;
      end
    end else begin
      if (w_pop) begin
        r_s0 <= r_s1;
      end
      if (w_ren) begin
        unique case (w_idx)
          NX_BUF_EMPTY: r_s0 <= fifo_rdata;
          NX_BUF_ONE:   r_s1 <= fifo_rdata;
          default:      r_s1 <= r_s1;
        endcase
      end
    end
  end

  assign fifo_ren  = w_ren;
  assign out_valid = r_valid;
  assign out_data  = r_s0;
  assign buf_cnt   = r_cnt;
  assign rd_count  = r_rd_cnt;

endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// Bench for nx_fifo_rd_stream against a 4-deep FIFO model.
// Scoreboard on delivered words plus cycle-level vector table.
module tb_nx_fifo_rd_stream;

  localparam int W  = 256;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rdata;
  logic          fifo_ren;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    buf_cnt;
  logic [CW-1:0] rd_count;

  nx_fifo_rd_stream #(
    .WIDTH(W), .CNT_W(CW), .DATA_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .buf_cnt(buf_cnt),
    .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // FIFO model, DEPTH=4
  logic         f_rst = 1'b1;
  logic         f_wen = 1'b0;
  logic [W-1:0] f_wdata = '0;
  logic [W-1:0] f_mem [4];
  logic [1:0]   f_wp, f_rp;
  logic [2:0]   f_used;
  logic         f_udf;

  assign fifo_empty = (f_used == 3'd0);
  assign fifo_rdata = f_mem[f_rp];

  always @(posedge clk) begin
    if (f_rst) begin
      f_wp <= '0; f_rp <= '0; f_used <= '0; f_udf <= 1'b0;
      for (int i = 0; i < 4; i++) f_mem[i] <= '0;
    end else begin
      logic wr, rd;
      wr = f_wen && (f_used < 3'd4);
      rd = fifo_ren && (f_used != 3'd0);
      if (fifo_ren && f_used == 3'd0) f_udf <= 1'b1;
      if (wr) begin
        f_mem[f_wp] <= f_wdata;
        f_wp <= f_wp + 2'd1;
      end
      if (rd) f_rp <= f_rp + 2'd1;
      f_used <= f_used + {2'b0, wr} - {2'b0, rd};
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_dlv = 0;
  logic [W-1:0] q[$];

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted word must be the oldest written
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_dlv++;
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_extra: got %0h want none", out_data);
      end else begin
        chk("sb_data", out_data, q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    f_wen = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] d);
    if (f_used < 3'd4) begin
      f_wen = 1'b1; f_wdata = d; q.push_back(d);
    end
  endtask

  task automatic do_reset(input int drop);
    tick(); rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rst_ren", W'(fifo_ren), '0);
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_cnt", W'(buf_cnt), '0);
    chk("rst_rdcnt", W'(rd_count), '0);
    chk("rst_data", out_data, '0);
    for (int i = 0; i < drop; i++) void'(q.pop_front());
    tick(); rst = 1'b0; f_rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget && (q.size() != 0 || out_valid); i++) begin
      tick(); @(negedge clk);
    end
    chk("drain_empty", W'(q.size()), '0);
  endtask

  typedef struct {
    logic         wen;
    logic [W-1:0] wd;
    logic         rdy;
    logic         e_ren;
    logic         e_val;
    logic [1:0]   e_cnt;
    logic [W-1:0] e_dat;
    logic [2:0]   e_used;
  } vec_t;

  vec_t tv[11];

  initial begin
    int nv, first, last;
    logic seen_ren, seen_v;
    logic [W-1:0] exp_first;

    tv[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 2, 0, 1, 0, 0, 0, 1};
    tv[2]  = '{1, 3, 0, 1, 1, 1, 1, 1};
    tv[3]  = '{1, 4, 0, 0, 1, 2, 1, 1};
    tv[4]  = '{0, 0, 0, 0, 1, 2, 1, 2};
    tv[5]  = '{0, 0, 0, 0, 1, 2, 1, 2};
    tv[6]  = '{0, 0, 1, 1, 1, 2, 1, 2};
    tv[7]  = '{0, 0, 1, 1, 1, 2, 2, 1};
    tv[8]  = '{0, 0, 1, 0, 1, 2, 3, 0};
    tv[9]  = '{0, 0, 1, 0, 1, 1, 4, 0};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0};

    do_reset(0);

    // backpressure vectors
    for (int i = 0; i < 11; i++) begin
      tick();
      out_ready = tv[i].rdy;
      if (tv[i].wen) wr(tv[i].wd);
      @(negedge clk);
      chk($sformatf("tv%0d_ren", i), W'(fifo_ren), W'(tv[i].e_ren));
      chk($sformatf("tv%0d_val", i), W'(out_valid), W'(tv[i].e_val));
      chk($sformatf("tv%0d_cnt", i), W'(buf_cnt), W'(tv[i].e_cnt));
      chk($sformatf("tv%0d_used", i), W'(f_used), W'(tv[i].e_used));
      if (tv[i].e_val)
        chk($sformatf("tv%0d_dat", i), out_data, tv[i].e_dat);
    end
    chk("tv_rdcnt", W'(rd_count), W'(4));

    // streaming 0x1..0x8 at full rate
    do_reset(0);
    out_ready = 1'b1;
    nv = 0; first = -1; last = -1;
    for (int k = 0; k < 16; k++) begin
      tick();
      out_ready = 1'b1;
      if (k < 8) wr(W'(k + 1));
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("st_nvalid", W'(nv), W'(8));
    chk("st_contig", W'(last - first), W'(7));
    chk("st_rdcnt", W'(rd_count), W'(8));

    // empty guard
    seen_ren = 1'b0; seen_v = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); out_ready = 1'b1;
      @(negedge clk);
      if (fifo_ren) seen_ren = 1'b1;
      if (out_valid) seen_v = 1'b1;
    end
    chk("eg_ren", W'(seen_ren), '0);
    chk("eg_udf", W'(f_udf), '0);
    chk("eg_valid", W'(seen_v), '0);

    // flush with A,B buffered and C,D in the FIFO
    do_reset(0);
    for (int k = 0; k < 6; k++) begin
      tick(); out_ready = 1'b0;
      if (k < 4) wr(W'(32'hA + k));
      @(negedge clk);
    end
    chk("fl_pre_cnt", W'(buf_cnt), W'(2));
    chk("fl_pre_dat", out_data, W'(32'hA));
    tick(); flush = 1'b1;
    @(negedge clk);
    chk("fl_ren", W'(fifo_ren), '0);
    tick();
    @(negedge clk);
    chk("fl_cnt", W'(buf_cnt), '0);
    chk("fl_valid", W'(out_valid), '0);
    chk("fl_data", out_data, '0);
    void'(q.pop_front());
    void'(q.pop_front());
    exp_first = '1;
    for (int k = 0; k < 5 && exp_first === '1; k++) begin
      tick(); out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) exp_first = out_data;
    end
    chk("fl_next", exp_first, W'(32'hC));
    drain(20);

    // reset with two words buffered, two left in FIFO
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(); out_ready = 1'b0;
      if (k < 4) wr(W'(32'h51 + k));
      @(negedge clk);
    end
    chk("rm_pre_cnt", W'(buf_cnt), W'(2));
    chk("rm_pre_used", W'(f_used), W'(2));
    do_reset(2);
    drain(20);

    // counter wrap with random backpressure
    do_reset(0);
    n_dlv = 0;
    begin
      int i;
      i = 0;
      for (int c = 0; c < 300 && i < 18; c++) begin
        tick();
        out_ready = 1'($urandom_range(0, 1));
        if (f_used < 3'd4 && $urandom_range(0, 2) != 0) begin
          wr(W'(32'h600 + i));
          i++;
        end
        @(negedge clk);
      end
      chk("wr_issued", W'(i), W'(18));
    end
    drain(60);
    chk("wr_dlv", W'(n_dlv), W'(18));
    chk("wr_rdcnt", W'(rd_count), W'(2));
    chk("wr_udf", W'(f_udf), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
